param_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO for buffering activations and weights between the 5x5 matrix datapath stages; the next generation of the team's 8-bit/64-deep sync FIFO.
- Adds parametrised data width and depth, a correctly sized occupancy count, a registered read port with a valid strobe, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_sdp_ram.sv | 34 +++
 rtl/param_sync_fifo.sv | 101 ++++++++++
 tb/tb_param_sync_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the parametrised sync FIFO.
// Defaults match the matrix datapath buffering.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;

  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, registered read.
// Kept free of FIFO control so block RAM can be inferred.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2w(DEF_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= mem[i_raddr];
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered read port,
// programmable thresholds, synchronous flush and sticky errors.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int AW      = clog2w(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_w_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_r_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rvalid,
  output logic [CW-1:0]     o_fifo_cnt,
  output logic              o_buf_empty,
  output logic              o_buf_full,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_ptr;
  logic [CW-1:0] cnt;
  logic          rvalid;
  logic          ovf;
  logic          udf;
  logic          empty;
  logic          full;
  logic          wr_acc;
  logic          rd_acc;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // Flush drops any request in the same cycle.
  assign wr_acc = i_w_en & ~full & ~i_flush;
  assign rd_acc = i_r_en & ~empty & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      cnt    <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (i_flush) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      cnt    <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (wr_acc) w_ptr <= w_ptr + AW'(1);
      if (rd_acc) r_ptr <= r_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (i_w_en & full)  ovf <= 1'b1;
      if (i_r_en & empty) udf <= 1'b1;
    end
  end

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (wr_acc),
    .i_waddr (w_ptr),
    .i_wdata (i_data),
    .i_re    (rd_acc),
    .i_raddr (r_ptr),
    .o_rdata (o_data)
  );

  assign o_rvalid       = rvalid;
  assign o_fifo_cnt     = cnt;
  assign o_buf_empty    = empty;
  assign o_buf_full     = full;
  assign o_almost_full  = (cnt >= CW'(AF_LEVEL));
  assign o_almost_empty = (cnt <= CW'(AE_LEVEL));
  assign o_overflow     = ovf;
  assign o_underflow    = udf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: queue model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_w_en;
  logic [DW-1:0] i_data;
  logic          i_r_en;
  logic [DW-1:0] o_data;
  logic          o_rvalid;
  logic [3:0]    o_fifo_cnt;
  logic          o_buf_empty;
  logic          o_buf_full;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic          o_overflow;
  logic          o_underflow;

  param_sync_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_w_en         (i_w_en),
    .i_data         (i_data),
    .i_r_en         (i_r_en),
    .o_data         (o_data),
    .o_rvalid       (o_rvalid),
    .o_fifo_cnt     (o_fifo_cnt),
    .o_buf_empty    (o_buf_empty),
    .o_buf_full     (o_buf_full),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  bit checking = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain queue plus the last word handed out.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  bit m_rv, m_ovf, m_udf;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q.delete();
      m_data = '0;
      m_rv = 0;
      m_ovf = 0;
      m_udf = 0;
    end else if (i_flush) begin
      q.delete();
      m_rv = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      bit was_full, was_empty;
      was_full = (q.size() == DP);
      was_empty = (q.size() == 0);
      m_rv = i_r_en && !was_empty;
      if (i_w_en && was_full) m_ovf = 1;
      if (i_r_en && was_empty) m_udf = 1;
      if (m_rv) m_data = q.pop_front();
      if (i_w_en && !was_full) q.push_back(i_data);
    end
  end

  always @(negedge i_clk) begin
    if (checking) begin
      chk("data", o_data, m_data);
      chk("rvalid", o_rvalid, m_rv);
      chk("cnt", o_fifo_cnt, q.size());
      chk("empty", o_buf_empty, q.size() == 0);
      chk("full", o_buf_full, q.size() == DP);
      chk("afull", o_almost_full, q.size() >= AF);
      chk("aempty", o_almost_empty, q.size() <= AE);
      chk("ovf", o_overflow, m_ovf);
      chk("udf", o_underflow, m_udf);
    end
  end

  task automatic step(input bit w, input logic [DW-1:0] d,
                      input bit r, input bit f);
    i_w_en = w;
    i_data = d;
    i_r_en = r;
    i_flush = f;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 0;
    i_flush = 0;
    i_w_en = 0;
    i_r_en = 0;
    i_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst cnt", o_fifo_cnt, 0);
    chk("rst empty", o_buf_empty, 1);
    chk("rst aempty", o_almost_empty, 1);
    chk("rst afull", o_almost_full, 0);
    chk("rst data", o_data, 0);
    i_rst_n = 1;
    checking = 1;

    // basic write then read
    step(1, 8'h11, 0, 0);
    chk("t1 cnt1", o_fifo_cnt, 1);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    chk("t1 cnt3", o_fifo_cnt, 3);
    step(0, 0, 1, 0);
    chk("t1 rv", o_rvalid, 1);
    chk("t1 d0", o_data, 8'h11);
    chk("t1 cnt2", o_fifo_cnt, 2);
    step(0, 0, 1, 0);
    chk("t1 d1", o_data, 8'h22);
    step(0, 0, 1, 0);
    chk("t1 d2", o_data, 8'h33);
    chk("t1 empty", o_buf_empty, 1);
    step(0, 0, 0, 0);
    chk("t1 rv off", o_rvalid, 0);

    // fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 4) chk("t2 af5", o_almost_full, 0);
      if (i == 5) chk("t2 af6", o_almost_full, 1);
    end
    chk("t2 full", o_buf_full, 1);
    step(1, 8'hAA, 0, 0);
    chk("t2 cnt", o_fifo_cnt, 8);
    chk("t2 ovf", o_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0);
      chk("t2 drain", o_data, i);
    end
    step(0, 0, 0, 1);

    // simultaneous requests
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h50, 1, 0);
    chk("t3 cnt4", o_fifo_cnt, 4);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'h70, 1, 0);
    chk("t3 cnt7", o_fifo_cnt, 7);
    chk("t3 ovf", o_overflow, 1);
    step(0, 0, 0, 1);
    step(1, 8'h80, 1, 0);
    chk("t3 cnt1", o_fifo_cnt, 1);
    chk("t3 udf", o_underflow, 1);
    chk("t3 rv", o_rvalid, 0);
    step(0, 0, 0, 1);

    // wrap-around
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'hC0 + i), 0, 0);
      step(0, 0, 1, 0);
      chk("t4 wrap", o_data, 8'hC0 + i);
    end
    chk("t4 ovf", o_overflow, 0);
    chk("t4 udf", o_underflow, 0);

    // flush with write pending
    for (int i = 0; i < 5; i++) step(1, 8'(i + 1), 0, 0);
    step(1, 8'hEE, 0, 1);
    chk("t5 cnt", o_fifo_cnt, 0);
    chk("t5 empty", o_buf_empty, 1);
    chk("t5 rv", o_rvalid, 0);
    step(0, 0, 1, 0);
    chk("t5 udf", o_underflow, 1);

    // async reset between edges
    step(1, 8'h5A, 0, 0);
    step(1, 8'h5B, 1, 0);
    #2 i_rst_n = 0;
    #1;
    chk("t6 cnt", o_fifo_cnt, 0);
    chk("t6 empty", o_buf_empty, 1);
    chk("t6 data", o_data, 0);
    chk("t6 rv", o_rvalid, 0);
    chk("t6 udf", o_underflow, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    step(1, 8'h77, 0, 0);
    step(0, 0, 1, 0);
    chk("t6 resume", o_data, 8'h77);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
    end

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
